// File: rtl/sample_play_ctrl_if.sv
// Sample playback controller bus bundle: sound-CPU register port plus the
// sample ROM address/data port and the DAC/status outputs.
interface sample_play_ctrl_if;
    logic        cpu_wr;
    logic [1:0]  cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [15:0] sample_addr_in;
    logic [1:0]  sample_addr_wr;
    logic        sample_inc;
    logic [7:0]  sample_data;
    logic [7:0]  dac_out;
    logic        busy;
    logic        end_pulse;

    // Environment side: CPU decode and sample ROM
    modport master (
        output cpu_wr, cpu_addr, cpu_din, sample_data,
        input  cpu_dout, sample_addr_in, sample_addr_wr, sample_inc,
               dac_out, busy, end_pulse
    );

    // Controller side
    modport slave (
        input  cpu_wr, cpu_addr, cpu_din, sample_data,
        output cpu_dout, sample_addr_in, sample_addr_wr, sample_inc,
               dac_out, busy, end_pulse
    );
endinterface

// File: rtl/sample_play_ctrl.sv
// Sample playback sequencer for the 256 KiB sample ROM port.
// CPU registers: 0 addr-lo, 1 addr-hi, 2 control {loop, stop, start}, 3 rate.
// Optional feature macro SAMPLE_LOOP_EN: control bit2 makes a start loop the
// sample (address reloaded from the start copy at each terminator) until stop.
module sample_play_ctrl #(
    parameter int         PRESCALE = 64,
    parameter int         ROM_LAT  = 2,
    parameter logic [7:0] DAC_IDLE = 8'h80
) (
    input  logic              clk,
    input  logic              reset_n,
    sample_play_ctrl_if.slave bus
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int LAT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
    // FETCH lasts ROM_LAT+1 cycles and CHECK one more; the first prescale step
    // after a WAIT reload is shortened by that overhead so CHECK-to-CHECK spacing
    // is exactly (rate+1)*PRESCALE.
    localparam int PRE_FIRST = PRESCALE - ROM_LAT - 3;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_WAIT, S_END} state_t;

    state_t           state_q;
    logic [LAT_W-1:0] lat_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       rcnt_q;
    logic [7:0]       rate_q;
    logic [12:0]      addr_in_q;
    logic [1:0]       addr_wr_q;
    logic             inc_q;
    logic [7:0]       dac_q;
    logic             busy_q;
    logic             end_pulse_q;
    logic             end_flag_q;
`ifdef SAMPLE_LOOP_EN
    logic             loop_q;
    logic [7:0]       lo_cpy_q;
    logic [4:0]       hi_cpy_q;
`endif

    logic wr_lo, wr_hi, wr_ctl, wr_rate, do_start, do_stop, tick;

    assign wr_lo    = bus.cpu_wr && (bus.cpu_addr == 2'd0);
    assign wr_hi    = bus.cpu_wr && (bus.cpu_addr == 2'd1);
    assign wr_ctl   = bus.cpu_wr && (bus.cpu_addr == 2'd2);
    assign wr_rate  = bus.cpu_wr && (bus.cpu_addr == 2'd3);
    assign do_stop  = wr_ctl && bus.cpu_din[1];
    assign do_start = wr_ctl && bus.cpu_din[0] && !bus.cpu_din[1];
    assign tick     = (pre_q == '0) && (rcnt_q == 8'd0);

    assign bus.cpu_dout       = {6'b000000, end_flag_q, busy_q};
    assign bus.sample_addr_in = {3'b000, addr_in_q};
    assign bus.sample_addr_wr = addr_wr_q;
    assign bus.sample_inc     = inc_q;
    assign bus.dac_out        = dac_q;
    assign bus.busy           = busy_q;
    assign bus.end_pulse      = end_pulse_q;

    // Register file, rate counter and playback FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            pre_q       <= '0;
            rcnt_q      <= 8'd0;
            rate_q      <= 8'hFF;
            addr_in_q   <= '0;
            addr_wr_q   <= 2'b00;
            inc_q       <= 1'b0;
            dac_q       <= DAC_IDLE;
            busy_q      <= 1'b0;
            end_pulse_q <= 1'b0;
            end_flag_q  <= 1'b0;
`ifdef SAMPLE_LOOP_EN
            loop_q      <= 1'b0;
            lo_cpy_q    <= 8'h00;
            hi_cpy_q    <= 5'h00;
`endif
        end else begin
            addr_wr_q   <= 2'b00;
            inc_q       <= 1'b0;
            end_pulse_q <= 1'b0;

            // Rate counter runs down to zero while busy and holds there
            if (busy_q && !tick) begin
                if (pre_q == '0) begin
                    pre_q  <= PRE_W'(PRESCALE - 1);
                    rcnt_q <= rcnt_q - 8'd1;
                end else begin
                    pre_q <= pre_q - PRE_W'(1);
                end
            end

            if (wr_rate) rate_q <= bus.cpu_din;
            if (wr_lo) begin
                addr_in_q[7:0] <= bus.cpu_din;
                addr_wr_q      <= 2'b01;
            end
            if (wr_hi) begin
                addr_in_q[12:8] <= bus.cpu_din[4:0];
                addr_wr_q       <= 2'b10;
            end

            if (do_stop) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                dac_q   <= DAC_IDLE;
            end else if (do_start) begin
                state_q    <= S_FETCH;
                lat_q      <= LAT_W'(ROM_LAT);
                busy_q     <= 1'b1;
                end_flag_q <= 1'b0;
                pre_q      <= PRE_W'(PRE_FIRST);
                rcnt_q     <= rate_q;
`ifdef SAMPLE_LOOP_EN
                loop_q     <= bus.cpu_din[2];
                lo_cpy_q   <= addr_in_q[7:0];
                hi_cpy_q   <= addr_in_q[12:8];
`endif
            end else if ((wr_lo || wr_hi) && busy_q) begin
                // The byte in flight belongs to the old address: refetch.
                // This also swallows the increment of a coinciding CHECK.
                state_q <= S_FETCH;
                lat_q   <= LAT_W'(ROM_LAT);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_FETCH: begin
                        if (lat_q == '0) state_q <= S_CHECK;
                        else             lat_q   <= lat_q - LAT_W'(1);
                    end
                    S_CHECK: begin
                        if (bus.sample_data == 8'h00) begin
                            state_q     <= S_END;
                            end_pulse_q <= 1'b1;
                            end_flag_q  <= 1'b1;
                            dac_q       <= DAC_IDLE;
`ifdef SAMPLE_LOOP_EN
                            if (loop_q) begin
                                addr_in_q <= {hi_cpy_q, lo_cpy_q};
                                addr_wr_q <= 2'b11;
                            end
`endif
                        end else begin
                            dac_q   <= bus.sample_data;
                            inc_q   <= 1'b1;
                            state_q <= S_WAIT;
                            pre_q   <= PRE_W'(PRE_FIRST);
                            rcnt_q  <= rate_q;
                        end
                    end
                    S_WAIT: begin
                        if (tick) begin
                            state_q <= S_FETCH;
                            lat_q   <= LAT_W'(ROM_LAT);
                        end
                    end
                    S_END: begin
`ifdef SAMPLE_LOOP_EN
                        if (loop_q) begin
                            state_q <= S_FETCH;
                            lat_q   <= LAT_W'(ROM_LAT);
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_play_ctrl.sv
// Testbench for sample_play_ctrl: ROM model, register-write vector table,
// hand-written corner sequences and randomized sample playback.
module tb_sample_play_ctrl;
    localparam int PRESCALE = 64;
    localparam int ROM_LAT  = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [1:0]  a;
        logic [7:0]  d;
        logic [1:0]  exp_wr;
        logic [15:0] exp_ain;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    sample_play_ctrl_if bus();

    sample_play_ctrl #(.PRESCALE(PRESCALE), .ROM_LAT(ROM_LAT), .DAC_IDLE(8'h80)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Sample ROM: address load/increment, ROM_LAT-deep read pipeline
    logic [7:0]  mem [0:262143];
    logic [17:0] rom_addr = '0;
    logic [7:0]  rom_p0 = 8'h00;
    logic [7:0]  rom_p1 = 8'h00;
    always @(posedge clk) begin
        if (bus.sample_addr_wr != 2'b00) begin
            if (bus.sample_addr_wr[0]) rom_addr[12:0]  <= {bus.sample_addr_in[7:0], 5'b00000};
            if (bus.sample_addr_wr[1]) rom_addr[17:13] <= bus.sample_addr_in[12:8];
        end else if (bus.sample_inc) begin
            rom_addr <= rom_addr + 18'd1;
        end
        rom_p0 <= mem[rom_addr];
        rom_p1 <= rom_p0;
    end
    assign bus.sample_data = rom_p1;

    // Event monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int         inc_cyc[$];
    logic [7:0] inc_dac[$];
    int end_cnt = 0, overlap = 0, wr_evt = 0;
    always @(negedge clk) begin
        if (bus.sample_inc) begin
            inc_cyc.push_back(cyc);
            inc_dac.push_back(bus.dac_out);
        end
        if (bus.end_pulse) end_cnt <= end_cnt + 1;
        if (bus.sample_addr_wr != 2'b00) wr_evt <= wr_evt + 1;
        if (bus.sample_inc && bus.sample_addr_wr != 2'b00) overlap <= overlap + 1;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic clr_log();
        inc_cyc.delete(); inc_dac.delete();
        end_cnt = 0; wr_evt = 0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!bus.busy) begin ok = 1'b1; return; end
            step(1);
        end
    endtask

    task automatic wait_incs(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (inc_cyc.size() >= n) begin ok = 1'b1; return; end
            step(1);
        end
    endtask

    // Reference: bytes played are those from the start address up to the terminator
    function automatic bq_t model_seq(input logic [17:0] a);
        bq_t q;
        logic [17:0] p = a;
        for (int i = 0; i < 64; i++) begin
            if (mem[p] == 8'h00) break;
            q.push_back(mem[p]);
            p = p + 18'd1;
        end
        return q;
    endfunction

    task automatic check_play(input string tag, input bq_t exp, input int rate, input bit spacing);
        int period = (rate + 1) * PRESCALE;
        chk({tag, "_ninc"}, inc_dac.size(), exp.size());
        for (int i = 0; i < exp.size() && i < inc_dac.size(); i++)
            chk({tag, "_dac"}, inc_dac[i], exp[i]);
        if (spacing)
            for (int i = 1; i < exp.size() && i < inc_cyc.size(); i++)
                chk({tag, "_period"}, inc_cyc[i] - inc_cyc[i-1], period);
        chk({tag, "_endcnt"}, end_cnt, 1);
        chk({tag, "_dacidle"}, bus.dac_out, 8'h80);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_dout"}, bus.cpu_dout, 8'h02);
    endtask

    vec_t tbl[6];

    initial begin
        bit ok;
        int target, guard;
        bq_t exp;
        logic [7:0]  lo;
        logic [4:0]  hi;
        logic [17:0] base;
        int len, rate;

        bus.cpu_wr = 1'b0; bus.cpu_addr = 2'd0; bus.cpu_din = 8'h00;
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h06240] = 8'h40; mem[18'h06241] = 8'h90; mem[18'h06242] = 8'h00;
        mem[18'h06680] = 8'h55; mem[18'h06681] = 8'h00;

        tbl[0] = '{2'd0, 8'hAB, 2'b01, 16'h00AB};
        tbl[1] = '{2'd1, 8'hFF, 2'b10, 16'h1FAB};
        tbl[2] = '{2'd3, 8'h00, 2'b00, 16'h1FAB};
        tbl[3] = '{2'd0, 8'h12, 2'b01, 16'h1F12};
        tbl[4] = '{2'd1, 8'h03, 2'b10, 16'h0312};
        tbl[5] = '{2'd2, 8'h00, 2'b00, 16'h0312};

        // Reset state
        #2 reset_n = 1'b0;
        step(3);
        chk("rst_dac", bus.dac_out, 8'h80);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_addr_wr", bus.sample_addr_wr, 2'b00);
        chk("rst_inc", bus.sample_inc, 1'b0);
        chk("rst_end", bus.end_pulse, 1'b0);
        chk("rst_dout", bus.cpu_dout, 8'h00);
        chk("rst_ain", bus.sample_addr_in, 16'h0000);
        reset_n = 1'b1;
        clr_log();
        step(10);
        chk("idle_wr_evt", wr_evt, 0);
        chk("idle_inc_evt", inc_cyc.size(), 0);

        // Register write vectors
        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].a, tbl[i].d);
            chk("vec_addr_wr", bus.sample_addr_wr, tbl[i].exp_wr);
            chk("vec_ain", bus.sample_addr_in, tbl[i].exp_ain);
            chk("vec_inc", bus.sample_inc, 1'b0);
            step(1);
            chk("vec_wr_once", bus.sample_addr_wr, 2'b00);
            chk("vec_busy", bus.busy, 1'b0);
        end

        // Rate 0 playback of 0x40, 0x90, terminator
        clr_log();
        wr(2'd3, 8'h00);
        wr(2'd2, 8'h01);
        chk("r0_busy", bus.busy, 1'b1);
        wait_idle(2000, ok);
        chk("r0_timeout", ok, 1'b1);
        check_play("r0", model_seq(18'h06240), 0, 1'b1);

        // Rate 3 spacing, stop mid-WAIT
        clr_log();
        wr(2'd3, 8'h03);
        wr(2'd0, 8'h12);
        wr(2'd2, 8'h01);
        chk("r3_dout_clr", bus.cpu_dout, 8'h01);
        wait_incs(2, 1500, ok);
        chk("r3_timeout", ok, 1'b1);
        if (inc_cyc.size() >= 2) chk("r3_period", inc_cyc[1] - inc_cyc[0], 256);
        step(50);
        wr(2'd2, 8'h02);
        chk("stop_busy", bus.busy, 1'b0);
        chk("stop_dac", bus.dac_out, 8'h80);
        step(400);
        chk("stop_no_end", end_cnt, 0);
        chk("stop_ninc", inc_cyc.size(), 2);
        chk("stop_dout", bus.cpu_dout, 8'h00);

        // Address write on the cycle CHECK would increment
        clr_log();
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h12);
        wr(2'd2, 8'h01);
        wait_incs(1, 200, ok);
        chk("col_timeout", ok, 1'b1);
        target = (inc_cyc.size() > 0) ? inc_cyc[0] + 62 : cyc;
        guard = 0;
        while (cyc < target && guard < 200) begin step(1); guard++; end
        wr(2'd0, 8'h34);
        chk("col_addr_wr", bus.sample_addr_wr, 2'b01);
        chk("col_inc", bus.sample_inc, 1'b0);
        wait_idle(2000, ok);
        chk("col_idle_timeout", ok, 1'b1);
        exp = '{8'h40, 8'h55};
        check_play("col", exp, 0, 1'b0);

        // Start and stop together: stop wins
        wr(2'd2, 8'h03);
        chk("both_busy", bus.busy, 1'b0);

        // Reset during playback
        clr_log();
        wr(2'd0, 8'h12);
        wr(2'd2, 8'h01);
        wait_incs(1, 200, ok);
        chk("rstmid_timeout", ok, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_dac", bus.dac_out, 8'h80);
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_ain", bus.sample_addr_in, 16'h0000);
        step(2);
        reset_n = 1'b1;

        // Control bit2 (loop request)
        clr_log();
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h12);
        wr(2'd1, 8'h03);
`ifdef SAMPLE_LOOP_EN
        wr(2'd2, 8'h05);
        wait_incs(4, 1500, ok);
        chk("loop_timeout", ok, 1'b1);
        exp = '{8'h40, 8'h90, 8'h40, 8'h90};
        for (int i = 0; i < 4 && i < inc_dac.size(); i++) chk("loop_dac", inc_dac[i], exp[i]);
        chk("loop_busy", bus.busy, 1'b1);
        chk("loop_end_seen", end_cnt >= 1, 1'b1);
        wr(2'd2, 8'h02);
        chk("loop_stop_busy", bus.busy, 1'b0);
`else
        wr(2'd2, 8'h05);
        wait_idle(2000, ok);
        chk("bit2_timeout", ok, 1'b1);
        check_play("bit2", model_seq(18'h06240), 0, 1'b1);
`endif

        // Randomized samples, addresses and rates
        for (int it = 0; it < 8; it++) begin
            lo   = 8'($urandom_range(0, 255));
            hi   = 5'($urandom_range(8, 31));
            len  = $urandom_range(0, 4);
            rate = $urandom_range(0, 2);
            base = {hi, lo, 5'b00000};
            for (int k = 0; k < len; k++) mem[base + 18'(k)] = 8'($urandom_range(1, 255));
            mem[base + 18'(len)] = 8'h00;
            clr_log();
            wr(2'd0, lo);
            wr(2'd1, {3'b000, hi});
            wr(2'd3, 8'(rate));
            wr(2'd2, 8'h01);
            wait_idle(2500, ok);
            chk("rnd_timeout", ok, 1'b1);
            check_play("rnd", model_seq(base), rate, 1'b1);
        end

        chk("no_inc_wr_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
